multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects, register, IR and memory write enables, and the 2-bit alu_op consumed by the ALU decoder.
- Sits beside the ALU decoder in the control unit; takes opcode from the IR, zero from the ALU, mem_ready from the memory.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- op  input  7  instruction opcode from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed the current access this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  0 = PC, 1 = ALU result register (memory address mux)
- mem_write  output  1  memory write request
- ir_write  output  1  IR/old-PC capture enable
- result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  output  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  output  2  00 = add, 01 = sub, 10 = decode by funct
- reg_write  output  1  register file write enable
- instr_done  output  1  one-cycle retire pulse

Behaviour:
- Moore FSM, with the exceptions noted below.
- State register async-cleared by rst_n low to FETCH. instr_done resets to 0.
- All outputs default to 0 in every state unless listed below.
- pc_write = pc_update | (branch & zero). pc_update and branch are internal.
- States and outputs:
  - FETCH: alu_src_a=00, alu_src_b=10, result_src=10. ir_write=pc_update=mem_ready (gated, so a stall never double-increments PC).
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1 (held until mem_ready).
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
- Transitions:
  - FETCH -> DECODE only when mem_ready=1; otherwise stay.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> FETCH (or TRAP, see Optional Feature)
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready; stall otherwise.
  - MEMWB -> FETCH.
  - MEMWRITE -> FETCH when mem_ready; stall otherwise.
  - EXECUTER/EXECUTEI/JAL -> ALUWB.
  - ALUWB -> FETCH.
  - BEQ -> FETCH.
- instr_done: registered. Set to 1 for exactly one cycle after any transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. Not set for an illegal opcode returning from DECODE.
- The op input is read only in DECODE and MEMADR; op changes in other states are ignored.
- rst_n asserted mid-instruction: immediate return to FETCH, all enables low while rst_n=0, any pending write abandoned.
- Cycle counts with mem_ready always 1:
  - lw: 5
  - sw: 4
  - R-type / I-type ALU: 4
  - jal: 4
  - beq: 3

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE -> TRAP state.
  - TRAP holds all enables at 0, is terminal until reset, and drives extra output illegal_instr=1.
- Undefined:
  - Unknown opcode -> FETCH with no side effects.
  - No TRAP state and no illegal_instr port.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (state_t)
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - alu_op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - result_src / alu_src_a / alu_src_b encodings
- The ALU decoder must import the same alu_op constants.
- No sub-module: next-state logic and output decode stay in one module.

Test Plan:
- Reset, mem_ready=1, op=0110011: state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH. alu_op=10 in EXECUTER, reg_write=1 in ALUWB, instr_done pulses in cycle 5.
- op=0000011, mem_ready low for 3 cycles in MEMREAD: MEMREAD held 4 cycles, adr_src=1 throughout, then MEMWB with result_src=01 and reg_write=1. Total 8 cycles.
- op=1100011, zero=1: in BEQ, pc_write=1 and alu_op=01. Repeat with zero=0: pc_write=0. Both return to FETCH.
- FETCH with mem_ready=0 for 2 cycles: ir_write=pc_write=0 during the stall, single pulse of each on the ready cycle.
- op=0100011: MEMWRITE with mem_write=1 until mem_ready; reg_write never 1; 4 cycles total.
- op=1111111: returns to FETCH with no writes and no instr_done. With ILLEGAL_TRAP_EN: TRAP with illegal_instr=1 until rst_n pulse.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// ctrl_pkg: shared state, opcode and datapath-select encodings for the multicycle RV32I control unit (macro ILLEGAL_TRAP_EN adds a TRAP state)
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore main controller sequencing fetch/decode/execute/memory/writeback; inputs op, zero, mem_ready; outputs enables, mux selects, alu_op, instr_done (ILLEGAL_TRAP_EN adds illegal_instr)
module multicycle_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       instr_done
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);
  state_t state, next;
  logic pc_update, branch, ir_w, mem_w, reg_w, done_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_FETCH;
      instr_done <= 1'b0;
    end else begin
      state      <= next;
      instr_done <= done_next;
    end
  always_comb begin
    next       = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_w       = mem_ready;
        pc_update  = mem_ready;
        next       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_RTYPE:          next = S_EXECR;
          OP_ITYPE:          next = S_EXECI;
          OP_BRANCH:         next = S_BEQ;
          OP_JAL:            next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           next = S_TRAP;
`else
          default:           next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next      = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        next    = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        next    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        next  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        next      = S_ALUWB;
      end
      default: next = state;
    endcase
  end
  // Only completed instructions retire; an illegal opcode leaving DECODE does not
  assign done_next = (next == S_FETCH) &&
                     (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});
  // FETCH is the reset state and would otherwise follow mem_ready while rst_n is low
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_w;
  assign mem_write = rst_n & mem_w;
  assign reg_write = rst_n & reg_w;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = rst_n & (state == S_TRAP);
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed table plus randomized instruction streams checked against a per-instruction cycle-expansion model
module tb_multicycle_control_fsm;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif
  int total = 0, bad = 0;
  logic pend = 1'b0;
  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [13:0] exp;
  } vec_t;
  vec_t q[$];
  vec_t tbl[4];
  logic [6:0] ops[7];

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .instr_done(instr_done)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb, ao,
                                     input logic rw, dn);
    return {pcw, adr, mw, irw, rs, sa, sb, ao, rw, dn};
  endfunction

  function automatic logic [13:0] got();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
            alu_src_b, alu_op, reg_write, instr_done};
  endfunction

  function automatic logic [4:0] enables();
    return {pc_write, mem_write, ir_write, reg_write, instr_done};
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic vec_t mkv(input logic [6:0] o, input logic z, r, input logic [13:0] e);
    vec_t v;
    v.op = o; v.zero = z; v.rdy = r; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [13:0] g, input logic [13:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, g, e);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    op = v.op; zero = v.zero; mem_ready = v.rdy;
    #2 chk(nm, got(), v.exp);
  endtask

  // Expand one instruction into its per-cycle expected outputs.
  // k: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal; fs/ms: fetch/memory stall cycles.
  task automatic gen(input int k, input int fs, input int ms, input logic z);
    logic [6:0] o;
    o = ops[k];
    for (int i = 0; i < fs; i++) begin
      q.push_back(mkv(r7(), rb(), 1'b0, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,pend)));
      pend = 1'b0;
    end
    q.push_back(mkv(r7(), rb(), 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,pend)));
    pend = 1'b0;
    q.push_back(mkv(o, rb(), rb(), mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0)));
    if (k <= 1) begin
      q.push_back(mkv(o, rb(), rb(), mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0)));
      for (int i = 0; i <= ms; i++)
        q.push_back(mkv(r7(), rb(), i == ms, mk(0,1,k == 1,0,2'b00,2'b00,2'b00,2'b00,0,0)));
      if (k == 0)
        q.push_back(mkv(r7(), rb(), rb(), mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0)));
      pend = 1'b1;
    end else if (k == 2 || k == 3 || k == 5) begin
      if (k == 5)
        q.push_back(mkv(r7(), rb(), rb(), mk(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0)));
      else
        q.push_back(mkv(r7(), rb(), rb(), mk(0,0,0,0,2'b00,2'b10,k == 3 ? 2'b01 : 2'b00,2'b10,0,0)));
      q.push_back(mkv(r7(), rb(), rb(), mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0)));
      pend = 1'b1;
    end else if (k == 4) begin
      q.push_back(mkv(r7(), z, rb(), mk(z,0,0,0,2'b00,2'b10,2'b00,2'b01,0,0)));
      pend = 1'b1;
    end
  endtask

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
    tbl[0] = mkv(7'b0110011, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0));
    tbl[1] = mkv(7'b0110011, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0));
    tbl[2] = mkv(7'b0110011, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0));
    tbl[3] = mkv(7'b0110011, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0));
    mem_ready = 1'b1;
    #12 chk("reset_enables", 14'(enables()), 14'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(tbl[i], "rtype_table");
    pend = 1'b1;
    gen(0, 0, 3, 1'b0);
    gen(4, 0, 0, 1'b1);
    gen(4, 0, 0, 1'b0);
    gen(2, 2, 0, 1'b0);
    gen(1, 0, 0, 1'b0);
    gen(1, 0, 2, 1'b0);
    gen(5, 0, 0, 1'b0);
    gen(3, 1, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
    gen(6, 0, 0, 1'b0);
    gen(2, 0, 0, 1'b0);
`endif
    for (int n = 0; n < 250; n++) begin
`ifdef ILLEGAL_TRAP_EN
      gen($urandom_range(5), $urandom_range(2), $urandom_range(2), rb());
`else
      gen($urandom_range(6), $urandom_range(2), $urandom_range(2), rb());
`endif
    end
    q.push_back(mkv(r7(), rb(), 1'b0, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,pend)));
    while (q.size() > 0) apply(q.pop_front(), "stream");
    apply(mkv(7'h00, 1'b0, 1'b1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0)), "abort_fetch");
    apply(mkv(7'b0100011, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0)), "abort_decode");
    apply(mkv(7'b0100011, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0)), "abort_memadr");
    apply(mkv(7'h00, 1'b0, 1'b0, mk(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0)), "abort_memwrite");
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2 chk("abort_in_reset", 14'(enables()), 14'd0);
    @(negedge clk);
    #2 chk("abort_held_reset", 14'(enables()), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("abort_refetch", got(), mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0));
`ifdef ILLEGAL_TRAP_EN
    apply(mkv(7'b1111111, 1'b0, 1'b1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0)), "trap_decode");
    for (int i = 0; i < 3; i++) begin
      apply(mkv(r7(), rb(), rb(), 14'd0), "trap_hold");
      chk("trap_flag", 14'(illegal_instr), 14'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("trap_cleared", 14'(illegal_instr), 14'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
